bids22_host: RTL
================

Name: bids22_host

Overview:
- Host-side controller sequencer that drives the auctioneer's controller port (C_op, C_data, C_start).
- Accepts high-level commands over a valid/ready interface and issues each one as a correctly timed op on the controller port.
- Checks the auctioneer's err, ready and roundOver responses, and returns one status/result beat per command.
- Sits between the testbench/CPU command source and the auctioneer's controller port.

Parameters:
- DATAWIDTH, 32, width of C_data, cmd_data and maxBid.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for ready or roundOver before reporting a timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  4  command: 0 NO_OP, 1 UNLOCK, 2 LOCK, 3 LOADX, 4 LOADY, 5 LOADZ, 6 SETMASK, 7 SETTIMER, 8 SETBIDCHARGE, 15 ROUND; others invalid
- cmd_data  in  DATAWIDTH  operand; for ROUND, number of C_start cycles
- C_op  out  4  op to auctioneer (encodings as cmd_op 0..8)
- C_data  out  DATAWIDTH  operand to auctioneer
- C_start  out  1  round-active strobe
- ready  in  1  auctioneer locked and ready for a round
- err  in  3  auctioneer error code; 0 = NOERROR
- roundOver  in  1  auctioneer round-complete pulse
- maxBid  in  DATAWIDTH  winning bid, valid while roundOver = 1
- rsp_valid  out  1  one-cycle response pulse
- rsp_status  out  2  0 OK, 1 DUT_ERR, 2 TIMEOUT, 3 BAD_CMD
- rsp_err  out  3  captured err value
- rsp_max_bid  out  DATAWIDTH  captured maxBid (ROUND only, else 0)

Behaviour:
- Reset (synchronous, highest priority, also mid-operation): state IDLE, cmd_ready=1, C_op=0, C_data=0, C_start=0, rsp_valid=0, rsp_status=0, rsp_err=0, rsp_max_bid=0, timer cleared. Any in-flight command is dropped; no response is emitted for it.
- All controller-port outputs are registered. C_op is 0 in every cycle except an ISSUE cycle.
- States:
  - IDLE: cmd_ready=1. On accept: opcode 0..8 -> ISSUE; opcode 15 -> WAIT_RDY; any other opcode -> RESP with BAD_CMD (no port activity).
  - ISSUE: C_op/C_data driven for exactly one cycle. err is sampled in that same cycle, because the auctioneer's err is combinational on C_op.
    - err != 0 -> DUT_ERR with rsp_err = err.
    - LOCK, or UNLOCK answered with err != 0 (bad key/cooldown) -> WAIT_RDY, keeping the captured err.
    - Otherwise -> RESP OK.
  - WAIT_RDY: timer counts up.
    - ready=1 -> START (ROUND) or RESP (LOCK/UNLOCK; status OK, or DUT_ERR if an err was captured).
    - timer reaches TIMEOUT_CYCLES-1 with ready still 0 -> RESP TIMEOUT.
  - START: C_start=1 for max(cmd_data,1) consecutive cycles. A 32-bit down-counter loads cmd_data-1, or 0 if cmd_data=0. Then -> WAIT_OVER.
  - WAIT_OVER: C_start=0; timer restarts at 0.
    - roundOver=1 -> capture maxBid into rsp_max_bid, then RESP OK.
    - timeout -> RESP TIMEOUT, rsp_max_bid=0.
  - RESP: rsp_valid=1 for one cycle with the stable fields, then -> IDLE.
- cmd_ready=0 in every state except IDLE.
- Field lifetime: rsp_* fields hold their values until the next RESP.
- Timer is DATAWIDTH-bit saturating; it is cleared on each state entry.
- Simultaneous ready and timeout in the same cycle: ready wins.
- Simultaneous roundOver and timeout in the same cycle: roundOver wins.

Optional Feature:
- Macro: BIDS22_HOST_CMDQ_EN.
- Defined: a 4-entry command FIFO sits in front of the sequencer.
  - cmd_ready = !full, independent of state.
  - The FIFO is popped on entry to a command's processing state, so back-to-back commands issue with a single IDLE cycle between responses.
  - Reset empties the FIFO.
  - Push and pop in the same cycle while full: the push is accepted.
- Undefined: no buffering; cmd_ready is 1 only in IDLE.

Test Plan:
1. After reset, SETBIDCHARGE data=5 with err=0 -> C_op=8, C_data=5 for exactly 1 cycle; rsp_valid next cycle with status OK, rsp_err=0.
2. LOCK data=0xA5 with ready asserted 3 cycles later -> one C_op=2 cycle, then rsp status OK on the cycle after ready rises.
3. ROUND data=4 with ready=1, then roundOver=1 and maxBid=0x37 two cycles after C_start falls -> C_start high exactly 4 cycles; rsp OK, rsp_max_bid=0x37.
4. UNLOCK with err=1 in the issue cycle and ready held low for 80 cycles -> rsp status TIMEOUT after 64 wait cycles, rsp_err=1.
5. cmd_op=12 -> rsp BAD_CMD, C_op stays 0. Then ROUND data=0 -> C_start high exactly 1 cycle.
6. Reset asserted in the middle of the START phase -> C_start=0 and cmd_ready=1 on the next cycle, no rsp_valid. With BIDS22_HOST_CMDQ_EN, 5 pushes without pops -> cmd_ready=0 after the 4th.

Source files
------------

// File: rtl/bids22_host.sv
// Host-side sequencer for the auctioneer controller port: one command in, one timed op out, one response back.
// Optional build macro BIDS22_HOST_CMDQ_EN adds a 4-entry command FIFO in front of the sequencer.
module bids22_host #(
    parameter int DATAWIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_op,
    input  logic [DATAWIDTH-1:0] cmd_data,
    output logic [3:0]           C_op,
    output logic [DATAWIDTH-1:0] C_data,
    output logic                 C_start,
    input  logic                 ready,
    input  logic [2:0]           err,
    input  logic                 roundOver,
    input  logic [DATAWIDTH-1:0] maxBid,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_status,
    output logic [2:0]           rsp_err,
    output logic [DATAWIDTH-1:0] rsp_max_bid
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_RDY, S_START, S_WAIT_OVER, S_RESP
    } state_t;

    typedef struct packed {
        logic [1:0]           status;
        logic [2:0]           err;
        logic [DATAWIDTH-1:0] max_bid;
    } rsp_t;

    localparam logic [3:0] OP_UNLOCK    = 4'd1;
    localparam logic [3:0] OP_LOCK      = 4'd2;
    localparam logic [3:0] OP_LAST_PORT = 4'd8;
    localparam logic [3:0] OP_ROUND     = 4'd15;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_DUT_ERR = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_BAD_CMD = 2'd3;

    localparam logic [DATAWIDTH-1:0] ONE      = DATAWIDTH'(1);
    localparam logic [DATAWIDTH-1:0] TMO_LAST = DATAWIDTH'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    logic [3:0]           r_c_op;
    logic [DATAWIDTH-1:0] r_c_data;
    logic                 r_c_start;
    logic                 r_rsp_valid;
    rsp_t                 r_rsp;
    logic [3:0]           r_cmd_op;
    logic [DATAWIDTH-1:0] r_cmd_data;
    logic [2:0]           r_err_cap;
    logic [DATAWIDTH-1:0] r_timer;
    logic [DATAWIDTH-1:0] r_start_cnt;

    logic                 w_take;
    logic [3:0]           w_op;
    logic [DATAWIDTH-1:0] w_data;
    logic                 w_timeout;

    function automatic rsp_t make_rsp(input logic [1:0] status, input logic [2:0] e,
                                      input logic [DATAWIDTH-1:0] bid);
        rsp_t r;
        r.status  = status;
        r.err     = e;
        r.max_bid = bid;
        return r;
    endfunction

`ifdef BIDS22_HOST_CMDQ_EN
    logic [3:0]           r_q_op   [4];
    logic [DATAWIDTH-1:0] r_q_data [4];
    logic [1:0]           r_wr_ptr;
    logic [1:0]           r_rd_ptr;
    logic [2:0]           r_count;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;

    assign w_full    = (r_count == 3'd4);
    assign w_pop     = (r_state == S_IDLE) && (r_count != 3'd0);
    // A pop in the same cycle frees a slot, so a full queue can still take a beat.
    assign cmd_ready = !w_full || w_pop;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_take    = w_pop;
    assign w_op      = r_q_op[r_rd_ptr];
    assign w_data    = r_q_data[r_rd_ptr];

    // NOTE: only pointers and count are reset; FIFO storage is never read before it is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_q_op[r_wr_ptr]   <= cmd_op;
                r_q_data[r_wr_ptr] <= cmd_data;
                r_wr_ptr           <= r_wr_ptr + 2'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    assign cmd_ready = (r_state == S_IDLE);
    assign w_take    = cmd_valid;
    assign w_op      = cmd_op;
    assign w_data    = cmd_data;
`endif

    assign w_timeout = (r_timer == TMO_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_c_op      <= '0;
            r_c_data    <= '0;
            r_c_start   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
            r_cmd_op    <= '0;
            r_cmd_data  <= '0;
            r_err_cap   <= '0;
            r_timer     <= '0;
            r_start_cnt <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_c_op      <= '0;
            r_c_data    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_cmd_op   <= w_op;
                        r_cmd_data <= w_data;
                        r_err_cap  <= '0;
                        r_timer    <= '0;
                        if (w_op <= OP_LAST_PORT) begin
                            r_c_op   <= w_op;
                            r_c_data <= w_data;
                            r_state  <= S_ISSUE;
                        end else if (w_op == OP_ROUND) begin
                            r_state <= S_WAIT_RDY;
                        end else begin
                            r_rsp       <= make_rsp(ST_BAD_CMD, 3'd0, '0);
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    // err is combinational on C_op, so it is only meaningful in this cycle.
                    r_err_cap <= err;
                    if (r_cmd_op == OP_LOCK || (r_cmd_op == OP_UNLOCK && err != 3'd0)) begin
                        r_timer <= '0;
                        r_state <= S_WAIT_RDY;
                    end else begin
                        r_rsp       <= make_rsp((err != 3'd0) ? ST_DUT_ERR : ST_OK, err, '0);
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_WAIT_RDY: begin
                    if (ready) begin
                        if (r_cmd_op == OP_ROUND) begin
                            r_c_start   <= 1'b1;
                            r_start_cnt <= (r_cmd_data == '0) ? '0 : r_cmd_data - ONE;
                            r_state     <= S_START;
                        end else begin
                            r_rsp       <= make_rsp((r_err_cap != 3'd0) ? ST_DUT_ERR : ST_OK,
                                                    r_err_cap, '0);
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end else if (w_timeout) begin
                        r_rsp       <= make_rsp(ST_TIMEOUT, r_err_cap, '0);
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + ONE;
                    end
                end
                S_START: begin
                    if (r_start_cnt == '0) begin
                        r_c_start <= 1'b0;
                        r_timer   <= '0;
                        r_state   <= S_WAIT_OVER;
                    end else begin
                        r_start_cnt <= r_start_cnt - ONE;
                    end
                end
                S_WAIT_OVER: begin
                    if (roundOver) begin
                        r_rsp       <= make_rsp(ST_OK, 3'd0, maxBid);
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_timeout) begin
                        r_rsp       <= make_rsp(ST_TIMEOUT, 3'd0, '0);
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + ONE;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign C_op        = r_c_op;
    assign C_data      = r_c_data;
    assign C_start     = r_c_start;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_status  = r_rsp.status;
    assign rsp_err     = r_rsp.err;
    assign rsp_max_bid = r_rsp.max_bid;

endmodule
